// File: rtl/cmem_port_arbiter.sv
// Round-robin arbiter for the character-buffer host port: requesters A and B plus an
// optional lowest-priority screen-clear engine, compiled in when CMEM_CLEAR_EN is defined.
module cmem_port_arbiter #(
    parameter int          CLR_WORDS = 800,
    parameter logic [31:0] FILL      = 32'h20202020,
    parameter logic [9:0]  IRQ_ADDR  = 10'd1022
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [9:0]  a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [9:0]  b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic        mwe,
    output logic [9:0]  maddr,
    output logic [31:0] mdin,
    input  logic [31:0] mdout,
    output logic        irq_clear
);

    logic        a_win_s;
    logic        b_win_s;
    logic        clr_win_s;
    logic        any_gnt_s;
    logic        sel_we_s;
    logic [9:0]  sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        clr_busy_s;
    logic [9:0]  clr_addr_s;

    logic        prefer_b_r;
    logic        mwe_r;
    logic [9:0]  maddr_r;
    logic [31:0] mdin_r;
    logic        irq_r;
    logic        a_rd_p1_r;
    logic        b_rd_p1_r;
    logic        a_rvalid_r;
    logic        b_rvalid_r;

`ifdef CMEM_CLEAR_EN
    localparam logic [9:0] CLR_LAST = 10'(CLR_WORDS - 1);

    logic        clr_busy_r;
    logic [9:0]  clr_cnt_r;

    // Clear engine: arm on clr_start when idle, advance one word per won cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_busy_r <= 1'b0;
            clr_cnt_r  <= 10'd0;
        end else if (!clr_busy_r) begin
            if (clr_start) begin
                clr_busy_r <= 1'b1;
                clr_cnt_r  <= 10'd0;
            end
        end else if (clr_win_s) begin
            if (clr_cnt_r == CLR_LAST) begin
                clr_busy_r <= 1'b0;
            end else begin
                clr_cnt_r <= clr_cnt_r + 10'd1;
            end
        end
    end

    assign clr_busy_s = clr_busy_r;
    assign clr_addr_s = clr_cnt_r;
`else
    logic clr_unused_s;

    assign clr_unused_s = &{1'b0, clr_start, CLR_WORDS[0]};
    assign clr_busy_s   = 1'b0;
    assign clr_addr_s   = 10'd0;
`endif

    // Arbitration: A/B contend round-robin, clear only takes otherwise idle cycles
    always_comb begin
        a_win_s   = 1'b0;
        b_win_s   = 1'b0;
        clr_win_s = 1'b0;
        if (reset) begin
            a_win_s   = 1'b0;
            b_win_s   = 1'b0;
            clr_win_s = 1'b0;
        end else if (a_req && b_req) begin
            a_win_s = !prefer_b_r;
            b_win_s = prefer_b_r;
        end else if (a_req) begin
            a_win_s = 1'b1;
        end else if (b_req) begin
            b_win_s = 1'b1;
        end else begin
            clr_win_s = clr_busy_s;
        end
    end

    assign any_gnt_s = a_win_s | b_win_s | clr_win_s;

    // Select the winning access for the memory-side registers
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = 10'd0;
        sel_wdata_s = 32'd0;
        if (a_win_s) begin
            sel_we_s    = a_we;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end else if (b_win_s) begin
            sel_we_s    = b_we;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else if (clr_win_s) begin
            sel_we_s    = 1'b1;
            sel_addr_s  = clr_addr_s;
            sel_wdata_s = FILL;
        end else begin
            sel_we_s    = 1'b0;
            sel_addr_s  = 10'd0;
            sel_wdata_s = 32'd0;
        end
    end

    // Round-robin pointer moves only on requester grants
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefer_b_r <= 1'b0;
        end else if (a_win_s) begin
            prefer_b_r <= 1'b1;
        end else if (b_win_s) begin
            prefer_b_r <= 1'b0;
        end
    end

    // Memory-side registers; address and data hold through idle cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mwe_r   <= 1'b0;
            maddr_r <= 10'd0;
            mdin_r  <= 32'd0;
            irq_r   <= 1'b0;
        end else begin
            mwe_r <= any_gnt_s & sel_we_s;
            irq_r <= (a_win_s | b_win_s) && (sel_addr_s == IRQ_ADDR);
            if (any_gnt_s) begin
                maddr_r <= sel_addr_s;
                mdin_r  <= sel_wdata_s;
            end
        end
    end

    // Two-stage read tracking so rvalid lines up with synchronous mdout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rd_p1_r  <= 1'b0;
            b_rd_p1_r  <= 1'b0;
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
        end else begin
            a_rd_p1_r  <= a_win_s & ~a_we;
            b_rd_p1_r  <= b_win_s & ~b_we;
            a_rvalid_r <= a_rd_p1_r;
            b_rvalid_r <= b_rd_p1_r;
        end
    end

    assign a_gnt     = a_win_s;
    assign b_gnt     = b_win_s;
    assign a_rvalid  = a_rvalid_r;
    assign b_rvalid  = b_rvalid_r;
    assign a_rdata   = mdout;
    assign b_rdata   = mdout;
    assign clr_busy  = clr_busy_s;
    assign mwe       = mwe_r;
    assign maddr     = maddr_r;
    assign mdin      = mdin_r;
    assign irq_clear = irq_r;

endmodule

// File: tb/tb_cmem_port_arbiter.sv
// Self-checking bench for cmem_port_arbiter: synchronous memory model plus a read-data
// scoreboard; clear-engine scenarios run when CMEM_CLEAR_EN is defined.
module tb_cmem_port_arbiter;

    localparam logic [31:0] FILL_V = 32'h20202020;
    localparam int          CLR_N  = 800;
    localparam logic [9:0]  IRQ_A  = 10'd1022;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we, clr_start;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, clr_busy, mwe, irq_clear;
    logic [31:0] a_rdata, b_rdata, mdin, mdout;
    logic [9:0]  maddr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t     qa[$];
    rd_exp_t     qb[$];
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    always #10 clk = ~clk;

    cmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .mwe(mwe), .maddr(maddr), .mdin(mdin), .mdout(mdout),
        .irq_clear(irq_clear)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    task automatic run_memory();
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
            if (mwe === 1'b1) mem[maddr] <= mdin;
            mdout <= mem[maddr];
        end
    endtask

    // Scoreboard: push expected read data at grant, pop when rvalid is due
    task automatic run_monitor();
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                qa.delete();
                qb.delete();
            end else begin
                checks++;
                if (qa.size() > 0 && qa[0].due == cyc) begin
                    e = qa.pop_front();
                    if (a_rvalid !== 1'b1 || a_rdata !== e.data) begin
                        errors++;
                        $display("FAIL a_read cyc %0d got rvalid=%b data=%h want rvalid=1 data=%h", cyc, a_rvalid, a_rdata, e.data);
                    end
                end else if (a_rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL a_rvalid_spurious cyc %0d got %b want 0", cyc, a_rvalid);
                end
                checks++;
                if (qb.size() > 0 && qb[0].due == cyc) begin
                    e = qb.pop_front();
                    if (b_rvalid !== 1'b1 || b_rdata !== e.data) begin
                        errors++;
                        $display("FAIL b_read cyc %0d got rvalid=%b data=%h want rvalid=1 data=%h", cyc, b_rvalid, b_rdata, e.data);
                    end
                end else if (b_rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL b_rvalid_spurious cyc %0d got %b want 0", cyc, b_rvalid);
                end
                if (a_gnt === 1'b1) begin
                    if (a_we) ref_mem[a_addr] = a_wdata;
                    else      qa.push_back('{data: ref_mem[a_addr], due: cyc + 2});
                end
                if (b_gnt === 1'b1) begin
                    if (b_we) ref_mem[b_addr] = b_wdata;
                    else      qb.push_back('{data: ref_mem[b_addr], due: cyc + 2});
                end
            end
        end
    endtask

    task automatic watchdog();
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_we = 1'b0; a_addr = 10'd0; a_wdata = 32'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 10'd0; b_wdata = 32'd0;
        clr_start = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_req = 1'b1; b_req = 1'b1; a_addr = IRQ_A; b_addr = IRQ_A; clr_start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({a_gnt, b_gnt} !== 2'b00) begin
            errors++; $display("FAIL reset_gnt got %b want 00", {a_gnt, b_gnt});
        end
        checks++;
        if ({mwe, irq_clear, a_rvalid, b_rvalid, clr_busy} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {mwe, irq_clear, a_rvalid, b_rvalid, clr_busy});
        end
        checks++;
        if (maddr !== 10'd0 || mdin !== 32'd0) begin
            errors++; $display("FAIL reset_mem got maddr=%h mdin=%h want 0 0", maddr, mdin);
        end
        idle_inputs();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({clr_busy, mwe} !== 2'b00) begin
            errors++; $display("FAIL reset_release got busy,mwe=%b want 00", {clr_busy, mwe});
        end
        next_cycle();
    endtask

    task automatic test_single_write();
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'd5; a_wdata = 32'h41424344;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            errors++; $display("FAIL write_gnt got %b want 10", {a_gnt, b_gnt});
        end
        next_cycle();
        a_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mwe, maddr, mdin, irq_clear} !== {1'b1, 10'd5, 32'h41424344, 1'b0}) begin
            errors++; $display("FAIL write_mem got mwe=%b maddr=%0d mdin=%h irq=%b want 1 5 41424344 0", mwe, maddr, mdin, irq_clear);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({mwe, maddr} !== {1'b0, 10'd5}) begin
            errors++; $display("FAIL write_hold got mwe=%b maddr=%0d want 0 5", mwe, maddr);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        apply_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'd10;
        b_req = 1'b1; b_we = 1'b0; b_addr = 10'd20;
        for (int k = 0; k < 6; k++) begin
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++;
            if ({a_gnt, b_gnt} !== exp_g) begin
                errors++; $display("FAIL contention_gnt step %0d got %b want %b", k, {a_gnt, b_gnt}, exp_g);
            end
            next_cycle();
            if (exp_g[1]) a_addr = a_addr + 10'd1;
            else          b_addr = b_addr + 10'd1;
        end
        idle_inputs();
        repeat (3) next_cycle();
    endtask

    task automatic test_irq();
        b_req = 1'b1; b_we = 1'b0; b_addr = IRQ_A;
        @(negedge clk);
        checks++;
        if ({b_gnt, irq_clear} !== 2'b10) begin
            errors++; $display("FAIL irq_g got gnt,irq=%b want 10", {b_gnt, irq_clear});
        end
        next_cycle();
        b_req = 1'b0;
        @(negedge clk);
        checks++;
        if (irq_clear !== 1'b1) begin
            errors++; $display("FAIL irq_g1 got %b want 1", irq_clear);
        end
        next_cycle();
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'd1021; a_wdata = 32'h5A5A0001;
        @(negedge clk);
        checks++;
        if (irq_clear !== 1'b0) begin
            errors++; $display("FAIL irq_g2 got %b want 0", irq_clear);
        end
        next_cycle();
        a_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({irq_clear, mwe, maddr} !== {1'b0, 1'b1, 10'd1021}) begin
            errors++; $display("FAIL irq_1021 got irq=%b mwe=%b maddr=%0d want 0 1 1021", irq_clear, mwe, maddr);
        end
        repeat (3) next_cycle();
    endtask

    task automatic test_back_to_back();
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'd30; a_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({a_gnt, b_gnt} !== 2'b10) begin
                errors++; $display("FAIL b2b_gnt step %0d got %b want 10", k, {a_gnt, b_gnt});
            end
            next_cycle();
            a_we = 1'b0;
            a_addr = 10'd30 + 10'(k % 2);
        end
        idle_inputs();
        repeat (3) next_cycle();
    endtask

`ifdef CMEM_CLEAR_EN
    task automatic start_clear();
        @(negedge clk);
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++; $display("FAIL clear_pre_busy got %b want 0", clr_busy);
        end
        clr_start = 1'b1;
        next_cycle();
        clr_start = 1'b0;
    endtask

    task automatic test_clear();
        logic [1:0] exp_bm;
        int bad;
        apply_reset();
        start_clear();
        for (int c = 1; c <= CLR_N + 5; c++) begin
            exp_bm = {(c <= CLR_N) ? 1'b1 : 1'b0, (c >= 2 && c <= CLR_N + 1) ? 1'b1 : 1'b0};
            @(negedge clk);
            checks++;
            if ({clr_busy, mwe} !== exp_bm) begin
                errors++; $display("FAIL clear_timing cyc %0d got busy,mwe=%b want %b", c, {clr_busy, mwe}, exp_bm);
            end
            if (exp_bm[0]) begin
                checks++;
                if (maddr !== 10'(c - 2) || mdin !== FILL_V) begin
                    errors++; $display("FAIL clear_word cyc %0d got maddr=%0d mdin=%h want %0d %h", c, maddr, mdin, c - 2, FILL_V);
                end
            end
            next_cycle();
            clr_start = (c == 99) ? 1'b1 : 1'b0;
        end
        bad = 0;
        for (int i = 0; i < CLR_N; i++) if (mem[i] !== FILL_V) bad++;
        checks++;
        if (bad != 0 || mem[CLR_N] !== init_word(CLR_N)) begin
            errors++; $display("FAIL clear_contents got %0d bad words, word %0d=%h want 0 bad, %h", bad, CLR_N, mem[CLR_N], init_word(CLR_N));
        end
    endtask

    task automatic test_clear_contention();
        int c;
        int n_a;
        int k;
        int low_at;
        apply_reset();
        start_clear();
        c = 1; n_a = 0; k = 0; low_at = -1;
        a_we = 1'b1;
        while (c < 2000 && low_at < 0) begin
            a_req   = (c % 3 == 0) ? 1'b1 : 1'b0;
            a_addr  = 10'(900 + (c / 3) % 100);
            a_wdata = 32'(c);
            @(negedge clk);
            if (a_req) begin
                checks++;
                if (a_gnt !== 1'b1) begin
                    errors++; $display("FAIL clear_a_gnt cyc %0d got %b want 1", c, a_gnt);
                end
            end
            if (a_gnt === 1'b1 && clr_busy === 1'b1) n_a++;
            if (mwe === 1'b1 && maddr < 10'd900) begin
                checks++;
                if (maddr !== 10'(k) || mdin !== FILL_V) begin
                    errors++; $display("FAIL clear_seq got maddr=%0d mdin=%h want %0d %h", maddr, mdin, k, FILL_V);
                end
                k++;
            end
            if (clr_busy !== 1'b1) low_at = c;
            next_cycle();
            c++;
        end
        idle_inputs();
        checks++;
        if (k != CLR_N || low_at != CLR_N + 1 + n_a) begin
            errors++; $display("FAIL clear_contended got words=%0d done_cyc=%0d want %0d %0d", k, low_at, CLR_N, CLR_N + 1 + n_a);
        end
        repeat (3) next_cycle();
    endtask

    task automatic test_reset_mid_clear();
        int active;
        apply_reset();
        start_clear();
        repeat (298) next_cycle();
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'd7;
        next_cycle();
        reset = 1'b1;
        #1;
        checks++;
        if ({a_gnt, b_gnt, mwe, irq_clear, a_rvalid, b_rvalid, clr_busy} !== 7'b0 || maddr !== 10'd0 || mdin !== 32'd0) begin
            errors++; $display("FAIL midclear_reset got gnt=%b%b mwe=%b irq=%b rv=%b%b busy=%b maddr=%0d mdin=%h want all 0",
                               a_gnt, b_gnt, mwe, irq_clear, a_rvalid, b_rvalid, clr_busy, maddr, mdin);
        end
        repeat (2) next_cycle();
        a_req = 1'b0;
        reset = 1'b0;
        active = 0;
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            if (mwe === 1'b1 || clr_busy === 1'b1) active++;
            next_cycle();
        end
        checks++;
        if (active != 0) begin
            errors++; $display("FAIL midclear_resume got %0d active cycles want 0", active);
        end
    endtask
`else
    task automatic test_clear_disabled();
        int active;
        clr_start = 1'b1;
        next_cycle();
        clr_start = 1'b0;
        active = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mwe === 1'b1 || clr_busy !== 1'b0) active++;
            next_cycle();
        end
        checks++;
        if (active != 0) begin
            errors++; $display("FAIL clear_disabled got %0d active cycles want 0", active);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        fork
            run_memory();
            run_monitor();
            watchdog();
        join_none
        test_reset();
        test_single_write();
        test_contention();
        test_irq();
        test_back_to_back();
`ifdef CMEM_CLEAR_EN
        test_clear();
        test_clear_contention();
        test_reset_mid_clear();
`else
        test_clear_disabled();
`endif
        repeat (2) next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmem_port_arbiter.md
# cmem_port_arbiter

Shares the character-buffer host port (the 32-bit, 1024-word B port of the text display memory) between two bus requesters, A (CPU) and B (physics status writer), plus an optional built-in screen-clear engine. It applies round-robin arbitration and registers the memory-side signals. It returns read data with a fixed latency and generates the `irq_clear` pulse for the 60 Hz display interrupt whenever word 1022 is accessed. It sits between the requesters and the display block's `mwe`/`maddr`/`mdin`/`mdout` pins.

## Interface
- `CLR_WORDS`, default 800: number of words written by the clear engine, starting at address 0 (80x40 characters, 4 per word).
- `FILL`, default 32'h20202020: data written by the clear engine (four spaces).
- `IRQ_ADDR`, default 10'd1022: an access to this address pulses `irq_clear`.
- `clk  in  1`  50 MHz system clock.
- `reset  in  1`  asynchronous, active-high reset.
- `a_req`, `b_req`  in  1 each: access request.
- `a_we`, `b_we`  in  1 each: 1 = write, 0 = read.
- `a_addr`, `b_addr`  in  10 each: word address.
- `a_wdata`, `b_wdata`  in  32 each: write data.
- `a_gnt`, `b_gnt`  out  1 each: combinational one-cycle grant.
- `a_rvalid`, `b_rvalid`  out  1 each: read data valid.
- `a_rdata`, `b_rdata`  out  32 each: read data.
- `clr_start`  in  1: start the clear engine.
- `clr_busy`  out  1: clear engine active.
- `mwe`  out  1: memory write enable.
- `maddr`  out  10: memory address.
- `mdin`  out  32: memory write data.
- `mdout`  in  32: memory read data; synchronous read, valid one cycle after address.
- `irq_clear`  out  1: one-cycle pulse.

## Operation
- Requester protocol:
  - The requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt` high at a rising edge.
  - It may drop `req` or present a new request in the following cycle.
  - Back-to-back grants to the same requester are allowed when the other requester is idle.
- Arbitration, at most one grant per cycle:
  - Only A requesting: grant A. Only B requesting: grant B.
  - Both requesting: grant the one not granted most recently. The round-robin pointer updates only on an A or B grant and resets to "prefer A".
- Clear engine:
  - Lowest priority. It takes the cycle only when neither `a_req` nor `b_req` is high.
  - Writes `FILL` to addresses 0 .. `CLR_WORDS`-1 in ascending order, one word per won cycle.
- `clr_start` sampled high while `clr_busy`=0: `clr_busy` goes high after that edge and the word counter is set to 0.
- `clr_start` while busy: ignored; the counter is not restarted.
- `clr_busy` falls after the edge that grants word `CLR_WORDS`-1.
- Granted access, the grant cycle being G: `maddr`, `mwe` (= we) and `mdin` are registered at the end of G and hold for cycle G+1.
- Cycles with no grant: `mwe`=0; `maddr` and `mdin` hold their last values.
- Reads:
  - `mdout` is valid in cycle G+2.
  - The owning `x_rvalid` is high for exactly cycle G+2, with `x_rdata` = `mdout` (combinational pass-through).
  - Writes never raise `rvalid`. The clear engine never raises either `rvalid`.
- `irq_clear` is high for cycle G+1 whenever the granted address equals `IRQ_ADDR`, for a read or a write from A or B.
- Reset, at any time including mid-clear or with reads in flight:
  - Outputs go to `mwe`=0, `maddr`=0, `mdin`=0, `irq_clear`=0, both `rvalid`=0, `clr_busy`=0. The `gnt` signals are forced to 0 while reset is high.
  - The clear is aborted with no resume.
  - In-flight reads are discarded.
  - The round-robin pointer returns to A.

## Timing
- Grant: combinational, in the same cycle as `req` when the requester wins.
- Memory-side signals: 1 cycle after the grant (G+1).
- Read data: `rvalid` in G+2. Latency is fixed at 2 cycles regardless of contention after the grant.
- Throughput: 1 access per cycle in total. Sustained A+B contention alternates A, B, A, B.
- Clear, uncontended, with `clr_start` sampled at edge 0:
  - `clr_busy` is high in cycles 1..`CLR_WORDS`.
  - `mwe` for word k is high in cycle k+2.
  - `clr_busy` is low from cycle `CLR_WORDS`+1.
- Each contended cycle delays clear completion by one cycle.

## Configuration
- `CMEM_CLEAR_EN` defined: the clear engine, `CLR_WORDS` and `FILL` are active as described.
- `CMEM_CLEAR_EN` undefined: no clear logic is compiled. `clr_start` is ignored, `clr_busy` is tied to 0, and the arbiter serves only A and B.

## Test plan
- A write at addr 5, data 32'h41424344, B idle -> `a_gnt` in cycle 0; `mwe`=1, `maddr`=5, `mdin`=32'h41424344 in cycle 1; no `rvalid`.
- A and B both read continuously for 6 cycles -> grants A,B,A,B,A,B; each `rvalid` arrives exactly 2 cycles after its grant with the matching memory model data.
- B read at addr 1022 -> `irq_clear` high for exactly cycle G+1 only; A write to 1021 -> no pulse.
- `clr_start` pulse, no contention, `CMEM_CLEAR_EN` defined -> 800 consecutive writes of 32'h20202020 to 0..799; `clr_busy` high for 800 cycles; a second `clr_start` at cycle 100 has no effect.
- Clear running, A requests every 3rd cycle -> A served immediately each time; clear finishes with all 800 words written, completion delayed by the count of A grants.
- `reset` asserted at cycle 300 of a clear with an A read in flight -> all outputs 0 immediately, no `rvalid`, clear does not resume after reset is released.
